// File: rtl/serial_nibble_packer.sv
// Serial-to-parallel word packer with per-word bit ordering and a small output FIFO.
// Feeds the lane-permutation stages; downstream back-pressure is absorbed by the FIFO.
module serial_nibble_packer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic                      in_bit,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [WIDTH-1:0]          out_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fill
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0]  shift_q, shift_d;
  logic [1:0]        word_mode_q, word_mode_d;

  logic [WIDTH-1:0]  fifo_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     fill_q;

  logic              accept;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  raw_word;
  logic [WIDTH-1:0]  packed_word;

  // A same-cycle pop is deliberately not considered: the slot frees one cycle later.
  assign in_ready  = !flush && !((bit_cnt_q == LastBit) && (fill_q == FullCnt));
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (fill_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_word  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign busy      = (bit_cnt_q != '0);
  assign fill      = fill_q;

  // The incoming bit lands on top; earlier bits have shifted down towards bit 0.
  assign raw_word = {in_bit, shift_q};

  always_comb begin
    packed_word = raw_word;
    case (word_mode_q)
      2'd1: begin
        for (int i = 0; i < WIDTH; i++) begin
          packed_word[i] = raw_word[WIDTH-1-i];
        end
      end
      2'd2:    packed_word = {raw_word[0], raw_word[WIDTH-1:1]};
      default: packed_word = raw_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_mode_d = word_mode_q;
    push        = 1'b0;

    if (flush) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (accept) begin
      shift_d = raw_word[WIDTH-1:1];
      unique case (state_q)
        StIdle: begin
          word_mode_d = mode;
          state_d     = StCollect;
          bit_cnt_d   = CntW'(1);
        end
        StCollect: begin
          if (bit_cnt_q == LastBit) begin
            push      = 1'b1;
            state_d   = StIdle;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      word_mode_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      word_mode_q <= word_mode_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= packed_word;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + (PtrW + 1)'(1);
        2'b01:   fill_q <= fill_q - (PtrW + 1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_packer.sv
// Bench for serial_nibble_packer: directed streams, a queue-based word model checked
// every cycle, plus hand-computed literal expectations.
module tb_serial_nibble_packer;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   mode;
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [$clog2(D):0] fill;

  int errors = 0;
  int checks = 0;

  serial_nibble_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bits collected so far, the mode latched with the first one, and the word queue.
  logic         m_bits [W];
  int           m_nbits = 0;
  int           m_mode  = 0;
  logic [W-1:0] m_q [$];

  function automatic logic [W-1:0] model_pack(input int m);
    logic [W-1:0] raw;
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) raw[i] = m_bits[i];
    for (int i = 0; i < W; i++) begin
      if (m == 1)      w[W-1-i] = m_bits[i];
      else if (m == 2) w[i]     = raw[(i + 1) % W];
      else             w[i]     = raw[i];
    end
    return w;
  endfunction

  // Compare on the falling edge, then advance the model with the inputs the next edge sees.
  always @(negedge clk) begin
    logic m_ready;
    logic m_pop;
    if (!rst_n) begin
      m_nbits = 0;
      m_mode  = 0;
      m_q.delete();
    end
    m_ready = !flush && !((m_nbits == W - 1) && (m_q.size() == D));
    check("out_valid", out_valid, (m_q.size() != 0));
    check("out_word", out_word, (m_q.size() != 0) ? m_q[0] : '0);
    check("fill", fill, m_q.size());
    check("busy", busy, (m_nbits != 0));
    check("in_ready", in_ready, m_ready);
    if (rst_n) begin
      m_pop = (m_q.size() != 0) && out_ready;
      if (m_pop) void'(m_q.pop_front());
      if (flush) begin
        m_nbits = 0;
      end else if (in_valid && m_ready) begin
        if (m_nbits == 0) m_mode = mode;
        m_bits[m_nbits] = in_bit;
        m_nbits++;
        if (m_nbits == W) begin
          m_q.push_back(model_pack(m_mode));
          m_nbits = 0;
        end
      end
    end
  end

  // Returns one time step after the edge that accepted the bit.
  task automatic send_bit(input logic b, input logic [1:0] m);
    logic acc;
    acc      = 1'b0;
    in_bit   = b;
    mode     = m;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [W-1:0] bits, input logic [1:0] m);
    for (int i = 0; i < W; i++) send_bit(bits[i], m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 2'd0;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_fill", fill, 0);
    #19 rst_n = 1'b1;
    idle(2);

    // Stream 1,0,1,1 under each ordering mode.
    send_word(4'b1101, 2'd0);
    check("lsb_valid", out_valid, 1);
    check("lsb_word", out_word, 4'b1101);
    idle(2);
    send_word(4'b1101, 2'd1);
    check("msb_word", out_word, 4'b1011);
    idle(2);
    send_word(4'b1101, 2'd2);
    check("rot_word", out_word, 4'b1110);
    idle(2);
    send_word(4'b0110, 2'd3);
    check("rsvd_word", out_word, 4'b0110);
    idle(2);

    // Back-pressure: two full words plus three bits, then the fourth bit stalls.
    out_ready = 1'b0;
    send_word(4'b1101, 2'd0);
    send_word(4'b1110, 2'd0);
    send_bit(1'b1, 2'd0);
    send_bit(1'b0, 2'd0);
    send_bit(1'b0, 2'd0);
    check("bp_fill_full", fill, 2);
    check("bp_busy", busy, 1);
    check("bp_stall", in_ready, 0);
    in_bit   = 1'b1;
    in_valid = 1'b1;
    idle(1);
    check("bp_still_stalled", in_ready, 0);
    check("bp_head", out_word, 4'b1101);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("bp_fill_after_pop", fill, 1);
    check("bp_ready_again", in_ready, 1);
    check("bp_head2", out_word, 4'b1110);
    idle(1);
    in_valid = 1'b0;
    check("bp_fill_done", fill, 2);
    check("bp_busy_done", busy, 0);
    out_ready = 1'b1;
    idle(1);
    check("bp_third_word", out_word, 4'b1001);
    idle(2);
    check("bp_drained", fill, 0);

    // Flush after two bits with one word queued.
    out_ready = 1'b0;
    send_word(4'b0011, 2'd0);
    send_bit(1'b1, 2'd0);
    send_bit(1'b1, 2'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_busy", busy, 0);
    check("fl_fill", fill, 1);
    check("fl_word", out_word, 4'b0011);
    send_word(4'b1000, 2'd1);
    check("fl_fill_new", fill, 2);
    out_ready = 1'b1;
    idle(1);
    check("fl_new_word", out_word, 4'b0001);
    idle(2);

    // Mode changes after bit 1: current word stays LSB-first, next is MSB-first.
    send_bit(1'b1, 2'd0);
    send_bit(1'b1, 2'd0);
    send_bit(1'b0, 2'd1);
    send_bit(1'b0, 2'd1);
    check("mm_first", out_word, 4'b0011);
    send_word(4'b0011, 2'd1);
    check("mm_second", out_word, 4'b1100);
    idle(2);

    // Asynchronous reset with two words queued and three bits in flight.
    out_ready = 1'b0;
    send_word(4'b1101, 2'd0);
    send_word(4'b0101, 2'd0);
    send_bit(1'b1, 2'd0);
    send_bit(1'b1, 2'd0);
    send_bit(1'b1, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_fill", fill, 0);
    check("ar_busy", busy, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_out_word", out_word, 0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send_word(4'b1101, 2'd0);
    check("ar_fresh_word", out_word, 4'b1101);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
